// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects the write-back value, waits on slow loads (timeout after 15 WAIT cycles) and forwards the registered result.
// Optional macro LOAD_SUBWORD_EN adds byte/halfword load extraction; otherwise loads write dm_rdata unchanged.
module mem_wb_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_mem_valid,
    input  logic [31:0] ex_mem_instruction,
    input  logic [1:0]  ex_mem_gpr_w_sel,
    input  logic [1:0]  ex_mem_wb_src,
    input  logic [31:0] ex_mem_alu_result,
    input  logic [31:0] ex_mem_pc,
    input  logic [31:0] dm_rdata,
    input  logic        dm_ready,
    input  logic        flush,
    output logic [31:0] mem_wb_instruction,
    output logic [1:0]  gpr_w_sel,
    output logic [31:0] gpr_w_data,
    output logic        mem_stall,
    output logic        fwd_valid,
    output logic [4:0]  fwd_reg,
    output logic [31:0] fwd_data,
    output logic        dm_err
);

    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;

    localparam logic [1:0] GPR_NONE = 2'b00;
    localparam logic [1:0] GPR_RD   = 2'b01;
    localparam logic [1:0] GPR_RT   = 2'b10;
    localparam logic [1:0] SRC_ALU  = 2'b00;
    localparam logic [1:0] SRC_MEM  = 2'b01;
    localparam logic [1:0] SRC_PC8  = 2'b10;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] instr_q, instr_d;
    logic [1:0]  sel_q, sel_d;
    logic [31:0] data_q, data_d;
    logic        err_q, err_d;
    logic        stall;
    logic        is_load;
    logic [31:0] load_data;
    logic [31:0] result;

`ifdef LOAD_SUBWORD_EN
    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    // Little-endian lanes; misaligned halfword low bit is ignored.
    always_comb begin
        ld_byte = dm_rdata[{ex_mem_alu_result[1:0], 3'b000} +: 8];
        ld_half = ex_mem_alu_result[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (ex_mem_instruction[31:26])
            OP_LB:   load_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  load_data = {24'h0, ld_byte};
            OP_LH:   load_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  load_data = {16'h0, ld_half};
            default: load_data = dm_rdata;
        endcase
    end
`else
    assign load_data = dm_rdata;
`endif

    always_comb begin
        case (ex_mem_wb_src)
            SRC_ALU: result = ex_mem_alu_result;
            SRC_MEM: result = load_data;
            SRC_PC8: result = ex_mem_pc + 32'd8;
            default: result = 32'h0;
        endcase
    end

    assign is_load = ex_mem_valid && (ex_mem_wb_src == SRC_MEM);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        instr_d = 32'h0;
        sel_d   = GPR_NONE;
        data_d  = 32'h0;
        err_d   = err_q;
        stall   = 1'b0;
        if (flush) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else begin
            case (state_q)
                RUN: begin
                    cnt_d = 4'd0;
                    if (ex_mem_valid) begin
                        if (!is_load || dm_ready) begin
                            instr_d = ex_mem_instruction;
                            sel_d   = ex_mem_gpr_w_sel;
                            data_d  = result;
                        end else begin
                            stall   = 1'b1;
                            state_d = WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (dm_ready) begin
                        instr_d = ex_mem_instruction;
                        sel_d   = ex_mem_gpr_w_sel;
                        data_d  = result;
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else if (cnt_q == 4'd14) begin
                        // 15th empty WAIT cycle: retire the load with zero data and
                        // release upstream so the same load is not reissued.
                        instr_d = ex_mem_instruction;
                        sel_d   = ex_mem_gpr_w_sel;
                        err_d   = 1'b1;
                        state_d = RUN;
                        cnt_d   = 4'd0;
                    end else begin
                        stall = 1'b1;
                        cnt_d = cnt_q + 4'd1;
                    end
                end
                default: state_d = RUN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
            instr_q <= 32'h0;
            sel_q   <= GPR_NONE;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            instr_q <= instr_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        case (sel_q)
            GPR_NONE: fwd_reg = 5'd0;
            GPR_RD:   fwd_reg = instr_q[15:11];
            GPR_RT:   fwd_reg = instr_q[20:16];
            default:  fwd_reg = 5'd31;
        endcase
    end

    assign mem_stall          = stall && !rst;
    assign mem_wb_instruction = instr_q;
    assign gpr_w_sel          = sel_q;
    assign gpr_w_data         = data_q;
    assign fwd_valid          = (sel_q != GPR_NONE) && (fwd_reg != 5'd0);
    assign fwd_data           = data_q;
    assign dm_err             = err_q;

endmodule

// File: doc/mem_wb_stage.md
MEM_WB_STAGE -- requirements
Module: mem_wb_stage

Interface
REQ-001 clk  in  1  single clock; all state updates on rising edge (GPR samples the outputs on the following falling edge).
REQ-002 rst  in  1  reset, synchronous, active-high.
REQ-003 ex_mem_valid  in  1  EX/MEM slot holds a real instruction.
REQ-004 ex_mem_instruction  in  32  instruction word in MEM.
REQ-005 ex_mem_gpr_w_sel  in  2  write select, `GPR_*` codes from ctrl_encode_def.v: 2'b00 none, 2'b01 RD, 2'b10 RT, 2'b11 RA.
REQ-006 ex_mem_wb_src  in  2  result source: 2'b00 ALU, 2'b01 MEM, 2'b10 PC+8 (link).
REQ-007 ex_mem_alu_result, ex_mem_pc  in  32 each  ALU result / load address; PC of the instruction.
REQ-008 dm_rdata  in  32, dm_ready  in  1  data-memory read data and valid strobe.
REQ-009 flush  in  1  kill the instruction currently in MEM.
REQ-010 mem_wb_instruction  out  32, gpr_w_sel  out  2, gpr_w_data  out  32  registered write-back to GPR.
REQ-011 mem_stall  out  1  combinational; freezes upstream stages.
REQ-012 fwd_valid  out  1, fwd_reg  out  5, fwd_data  out  32  forwarding of the registered result.
REQ-013 dm_err  out  1  sticky data-memory timeout flag.

Function
REQ-014 FSM states RUN, WAIT; RUN entered on reset.
REQ-015 RUN, valid non-load (wb_src != MEM): next edge registers instruction, gpr_w_sel, data; latency 1 cycle.
REQ-016 Data = alu_result for ALU, ex_mem_pc + 8 (32-bit wrap) for PC+8, extracted load data for MEM; wb_src 2'b11 writes 0.
REQ-017 RUN, valid load with dm_ready=1: registered in 1 cycle, no stall.
REQ-018 RUN, valid load with dm_ready=0: mem_stall=1 same cycle; next state WAIT; bubble registered (gpr_w_sel=none, instruction=0).
REQ-019 WAIT: mem_stall = !dm_ready; 4-bit wait counter increments each WAIT cycle; bubble held.
REQ-020 WAIT with dm_ready=1: load result registered, mem_stall=0 that cycle, return to RUN.
REQ-021 WAIT counter reaching 15 without dm_ready: dm_err set, result registered with data 32'h0000_0000, return to RUN.
REQ-022 ex_mem_valid=0: bubble registered.
REQ-023 flush=1 (RUN or WAIT): bubble registered, mem_stall=0, state RUN, counter cleared; flush wins over simultaneous dm_ready.
REQ-024 Loads decoded from opcode [31:26]: 0x23 LW, 0x20 LB, 0x24 LBU, 0x21 LH, 0x25 LHU; little-endian, byte k = dm_rdata[8k+7:8k], k = alu_result[1:0].
REQ-025 LB/LH sign-extend, LBU/LHU zero-extend; LH/LHU use halfword alu_result[1]; misaligned low bits ignored.
REQ-026 fwd_reg = rd [15:11] for RD, rt [20:16] for RT, 31 for RA, taken from the registered instruction; fwd_data = gpr_w_data.
REQ-027 fwd_valid = (gpr_w_sel != none) && (fwd_reg != 0); writes to R0 still reach GPR.

Reset
REQ-028 rst=1: mem_wb_instruction=0, gpr_w_sel=2'b00, gpr_w_data=0, state RUN, counter 0, dm_err=0, fwd_valid=0.
REQ-029 rst mid-WAIT aborts the load; no write-back issued for it.
REQ-030 mem_stall=0 while rst=1.

Configuration
REQ-031 LOAD_SUBWORD_EN defined: REQ-024/025 byte and halfword extraction built in.
REQ-032 LOAD_SUBWORD_EN undefined: every MEM-source load writes dm_rdata unmodified; no extraction logic.

Verification
REQ-033 ADD rd=8, alu_result=32'h1234, wb_src ALU, sel RD -> next cycle gpr_w_sel=01, gpr_w_data=32'h1234, fwd_reg=8, fwd_valid=1.
REQ-034 LB (SUBWORD_EN), addr[1:0]=2, dm_rdata=32'h0080_0000, dm_ready=1 -> gpr_w_data=32'hFFFF_FF80; LBU -> 32'h0000_0080.
REQ-035 LW, dm_ready low 3 cycles -> mem_stall high 3 cycles, bubbles, then result registered the cycle dm_ready rises.
REQ-036 LW, dm_ready never rises -> after 15 WAIT cycles dm_err=1, gpr_w_data=0, state RUN.
REQ-037 JAL, pc=32'hFFFF_FFFC, wb_src PC+8, sel RA -> gpr_w_data=32'h0000_0004, fwd_reg=31.
REQ-038 flush in WAIT with dm_ready=1 -> bubble, mem_stall=0; rst mid-WAIT -> all outputs at reset values.
